// File: rtl/peripheral_slave_port_if.sv
// Bus bundle between N requesting masters, the slave-port arbiter and a single slave.
// The slave modport is the arbiter's view; the master modport is the requesters'/slave model's view.
interface peripheral_slave_port_if #(
  parameter int unsigned N_MASTER   = 16,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = N_MASTER
);
  // Master side
  logic [N_MASTER-1:0]                 data_req_i;
  logic [N_MASTER-1:0][ADDR_WIDTH-1:0] data_add_i;
  logic [N_MASTER-1:0]                 data_wen_i;
  logic [N_MASTER-1:0][DATA_WIDTH-1:0] data_wdata_i;
  logic [N_MASTER-1:0][BE_WIDTH-1:0]   data_be_i;
  logic [N_MASTER-1:0][ID_WIDTH-1:0]   data_ID_i;
  logic [N_MASTER-1:0]                 data_gnt_o;
  logic [N_MASTER-1:0]                 data_r_valid_o;
  logic [DATA_WIDTH-1:0]               data_r_rdata_o;
  logic                                data_r_opc_o;

  // Slave side
  logic                                data_req_o;
  logic [ADDR_WIDTH-1:0]               data_add_o;
  logic                                data_wen_o;
  logic [DATA_WIDTH-1:0]               data_wdata_o;
  logic [BE_WIDTH-1:0]                 data_be_o;
  logic                                data_gnt_i;
  logic [DATA_WIDTH-1:0]               data_r_rdata_i;
  logic                                data_r_opc_i;

  modport slave (
    input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
    output data_gnt_o, data_r_valid_o, data_r_rdata_o, data_r_opc_o,
    output data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
    input  data_gnt_i, data_r_rdata_i, data_r_opc_i
  );

  modport master (
    output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
    input  data_gnt_o, data_r_valid_o, data_r_rdata_o, data_r_opc_o,
    input  data_req_o, data_add_o, data_wen_o, data_wdata_o, data_be_o,
    output data_gnt_i, data_r_rdata_i, data_r_opc_i
  );
endinterface

// File: rtl/peripheral_slave_port.sv
// Round-robin N-master to single-slave port with one-hot ID response routing.
// Define PE_SLAVE_RESP_REG_EN to register the response path (2-cycle latency instead of 1).
module peripheral_slave_port #(
  parameter int unsigned N_MASTER   = 16,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = N_MASTER
) (
  input logic                     clk,
  input logic                     rst_n,
  peripheral_slave_port_if.slave  bus
);

  localparam int unsigned RrWidth = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

  logic [RrWidth-1:0]  rr_q, rr_d;
  logic [RrWidth-1:0]  winner;
  logic [RrWidth-1:0]  cand;
  int unsigned         idx;
  logic                found;
  logic                any_req;
  logic                accept;
  logic [ID_WIDTH-1:0] rsp_id_q, rsp_id_d;

  assign any_req = |bus.data_req_i;
  assign accept  = any_req & bus.data_gnt_i;

  // First requester at or above rr_q, wrapping past the top index.
  always_comb begin
    winner = '0;
    cand   = '0;
    idx    = 0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N_MASTER; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= N_MASTER) idx = idx - N_MASTER;
      cand = RrWidth'(idx);
      if (!found && bus.data_req_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Request path and grant; everything is forced low while in reset.
  always_comb begin
    bus.data_req_o   = 1'b0;
    bus.data_add_o   = '0;
    bus.data_wen_o   = 1'b0;
    bus.data_wdata_o = '0;
    bus.data_be_o    = '0;
    bus.data_gnt_o   = '0;
    if (rst_n && any_req) begin
      bus.data_req_o         = 1'b1;
      bus.data_add_o         = bus.data_add_i[winner];
      bus.data_wen_o         = bus.data_wen_i[winner];
      bus.data_wdata_o       = bus.data_wdata_i[winner];
      bus.data_be_o          = bus.data_be_i[winner];
      bus.data_gnt_o[winner] = bus.data_gnt_i;
    end
  end

  always_comb begin
    rr_d     = rr_q;
    rsp_id_d = '0;
    if (accept) begin
      rr_d     = (winner == RrWidth'(N_MASTER - 1)) ? '0 : winner + RrWidth'(1);
      rsp_id_d = bus.data_ID_i[winner];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= '0;
      rsp_id_q <= '0;
    end else begin
      rr_q     <= rr_d;
      rsp_id_q <= rsp_id_d;
    end
  end

`ifdef PE_SLAVE_RESP_REG_EN
  logic [N_MASTER-1:0]   valid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  opc_q;

  // Data only reloads on a live response so the last beat stays visible between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rdata_q <= '0;
      opc_q   <= 1'b0;
    end else begin
      valid_q <= N_MASTER'(rsp_id_q);
      if (|rsp_id_q) begin
        rdata_q <= bus.data_r_rdata_i;
        opc_q   <= bus.data_r_opc_i;
      end
    end
  end

  assign bus.data_r_valid_o = valid_q;
  assign bus.data_r_rdata_o = rdata_q;
  assign bus.data_r_opc_o   = opc_q;
`else
  assign bus.data_r_valid_o = N_MASTER'(rsp_id_q);
  assign bus.data_r_rdata_o = rst_n ? bus.data_r_rdata_i : '0;
  assign bus.data_r_opc_o   = rst_n & bus.data_r_opc_i;
`endif

endmodule

// File: tb/tb_peripheral_slave_port.sv
// Randomized and directed bench for peripheral_slave_port against a cycle-level behavioural model.
module tb_peripheral_slave_port;

  localparam int unsigned NM = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned IW = NM;
`ifdef PE_SLAVE_RESP_REG_EN
  localparam int unsigned Lat = 2;
`else
  localparam int unsigned Lat = 1;
`endif

  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_pass;

  // Model state: rr pointer, IDs accepted 1 and 2 cycles ago, held response data
  int unsigned   m_rr;
  logic [NM-1:0] m_pend1, m_pend2;
  logic [DW-1:0] m_rd_hold;
  logic          m_opc_hold;
  logic          m_acc;
  logic [IW-1:0] m_acc_id;
  int unsigned   m_acc_w;
  logic [DW-1:0] m_cur_rd;
  logic          m_cur_opc;

  logic [NM-1:0] seq37 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [NM-1:0] seq36 [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};

  peripheral_slave_port_if #(
    .N_MASTER(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .ID_WIDTH(IW)
  ) bus ();

  peripheral_slave_port #(
    .N_MASTER(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .ID_WIDTH(IW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  function automatic int find_winner(input logic [NM-1:0] req, input int unsigned rr);
    for (int unsigned i = 0; i < NM; i++) begin
      int unsigned k;
      k = (rr + i) % NM;
      if (req[k]) return int'(k);
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_rr       = 0;
    m_pend1    = '0;
    m_pend2    = '0;
    m_rd_hold  = '0;
    m_opc_hold = 1'b0;
    m_acc      = 1'b0;
    m_acc_id   = '0;
    m_acc_w    = 0;
  endtask

  task automatic check_outputs();
    int            w;
    logic [1:0]    wi;
    logic          eq, ewen, eo;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd, er;
    logic [BW-1:0] ebe;
    logic [NM-1:0] eg, ev;
    eq = 1'b0; ewen = 1'b0; eo = 1'b0; ea = '0; ewd = '0; er = '0; ebe = '0; eg = '0; ev = '0;
    m_acc    = 1'b0;
    m_acc_id = '0;
    w = find_winner(bus.data_req_i, m_rr);
    m_cur_rd  = bus.data_r_rdata_i;
    m_cur_opc = bus.data_r_opc_i;
    if (rst_n) begin
      if (w >= 0) begin
        wi       = w[1:0];
        eq       = 1'b1;
        ea       = bus.data_add_i[wi];
        ewen     = bus.data_wen_i[wi];
        ewd      = bus.data_wdata_i[wi];
        ebe      = bus.data_be_i[wi];
        eg[wi]   = bus.data_gnt_i;
        m_acc    = bus.data_gnt_i;
        m_acc_id = bus.data_ID_i[wi];
        m_acc_w  = int'(wi);
      end
`ifdef PE_SLAVE_RESP_REG_EN
      ev = m_pend2;
      er = m_rd_hold;
      eo = m_opc_hold;
`else
      ev = m_pend1;
      er = bus.data_r_rdata_i;
      eo = bus.data_r_opc_i;
`endif
    end
    check("req_o",   64'(bus.data_req_o),     64'(eq));
    check("add_o",   64'(bus.data_add_o),     64'(ea));
    check("wen_o",   64'(bus.data_wen_o),     64'(ewen));
    check("wdata_o", 64'(bus.data_wdata_o),   64'(ewd));
    check("be_o",    64'(bus.data_be_o),      64'(ebe));
    check("gnt_o",   64'(bus.data_gnt_o),     64'(eg));
    check("valid_o", 64'(bus.data_r_valid_o), 64'(ev));
    check("rdata_o", 64'(bus.data_r_rdata_o), 64'(er));
    check("opc_o",   64'(bus.data_r_opc_o),   64'(eo));
  endtask

  task automatic model_edge();
    if (!rst_n) return;
`ifdef PE_SLAVE_RESP_REG_EN
    if (|m_pend1) begin
      m_rd_hold  = m_cur_rd;
      m_opc_hold = m_cur_opc;
    end
    m_pend2 = m_pend1;
`endif
    m_pend1 = m_acc ? m_acc_id : '0;
    if (m_acc) m_rr = (m_acc_w + 1) % NM;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic [NM-1:0] req, input logic gnt);
    bus.data_req_i = req;
    bus.data_gnt_i = gnt;
    for (int i = 0; i < NM; i++) begin
      bus.data_add_i[i]   = $urandom;
      bus.data_wdata_i[i] = $urandom;
      bus.data_be_i[i]    = BW'($urandom);
      bus.data_wen_i[i]   = 1'($urandom_range(0, 1));
      bus.data_ID_i[i]    = IW'(1) << i;
    end
    bus.data_r_rdata_i = $urandom;
    bus.data_r_opc_i   = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    drive('0, 1'b0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    model_reset();
    drive('0, 1'b0);
    step();
    drive(4'hF, 1'b1);
    step();
    rst_n = 1'b1;

    // All masters request, slave stalls 3 cycles, then grants sweep the ring
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(4'hF, 1'b0);
      step();
    end
    for (int k = 0; k < 5; k++) begin
      drive(4'hF, 1'b1);
      #1;
      check("seq_all4", 64'(bus.data_gnt_o), 64'(seq37[k]));
      step();
    end

    // Masters 0 and 2 alternate
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(4'b0101, 1'b1);
      #1;
      check("seq_0_2", 64'(bus.data_gnt_o), 64'(seq36[k]));
      step();
    end
    for (int k = 0; k < 3; k++) begin
      drive('0, 1'b1);
      step();
    end

    // Master 3 wins, pointer wraps, master 0 next
    do_reset();
    drive(4'b1000, 1'b1);
    step();
    drive(4'b1001, 1'b1);
    #1;
    check("wrap_gnt0", 64'(bus.data_gnt_o), 64'(4'b0001));
    step();
    drive('0, 1'b0);
    step();
    step();

    // Master 1 read with error response
    do_reset();
    drive(4'b0010, 1'b1);
    bus.data_wen_i[1] = 1'b1;
    step();
    for (int unsigned c = 1; c <= Lat; c++) begin
      drive('0, 1'b0);
      if (c == 1) begin
        bus.data_r_rdata_i = 32'hDEADBEEF;
        bus.data_r_opc_i   = 1'b1;
      end
      #1;
      if (c == Lat) begin
        check("rd_valid", 64'(bus.data_r_valid_o), 64'(4'b0010));
        check("rd_data",  64'(bus.data_r_rdata_o), 64'(32'hDEADBEEF));
        check("rd_opc",   64'(bus.data_r_opc_o),   64'(1'b1));
      end
      step();
    end

    // Reset the cycle after acceptance drops the response
    do_reset();
    drive(4'b0010, 1'b1);
    step();
    rst_n = 1'b0;
    model_reset();
    drive('0, 1'b0);
    #1;
    check("rst_valid", 64'(bus.data_r_valid_o), 64'(0));
    check("rst_rdata", 64'(bus.data_r_rdata_o), 64'(0));
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive('0, 1'b0);
      #1;
      check("post_rst_valid", 64'(bus.data_r_valid_o), 64'(0));
      step();
    end

    // Single master streaming back-to-back
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(4'b0100, 1'b1);
      step();
    end

    // Random traffic, occasional non-one-hot IDs and stalls
    do_reset();
    for (int k = 0; k < 400; k++) begin
      drive(NM'($urandom), $urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < NM; i++) bus.data_ID_i[i] = IW'($urandom);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
